mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared single-port synchronous `memory` model. It sits between the instruction-fetch stage and the data-memory stage of the pipeline and converts two request/ready handshakes into one memory command per cycle. It tracks outstanding reads and returns each read's data to its owner with a valid pulse. Data accesses take priority, and a wait counter bounds how long instruction fetch can be starved.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_return.sv | 36 +++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int unsigned WaitBits = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic {
        ST_DPRI = 1'b0,
        ST_IPRI = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arb_return.sv
// Two-stage read-owner pipeline; steers memory read data to the requester that issued it.
module mem_arb_return
    import mem_arb_pkg::*;
#(
    parameter int unsigned WordSize = 32
) (
    input  logic                Clock,
    input  logic                nReset,
    input  owner_t              issue,
    input  logic [WordSize-1:0] mem_read_data,
    output logic                i_valid,
    output logic [WordSize-1:0] i_data,
    output logic                d_valid,
    output logic [WordSize-1:0] d_data
);

    owner_t own_cmd;
    owner_t own_ret;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            own_cmd <= OWN_NONE;
            own_ret <= OWN_NONE;
        end else begin
            own_cmd <= issue;
            own_ret <= own_cmd;
        end
    end

    // Data is zeroed outside its valid cycle so neither consumer sees the other's reads.
    assign i_valid = (own_ret == OWN_I);
    assign d_valid = (own_ret == OWN_D);
    assign i_data  = i_valid ? mem_read_data : '0;
    assign d_data  = d_valid ? mem_read_data : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory,
// with data priority and a bounded wait for instruction fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AddressSize = 16,
    parameter int unsigned WordSize    = 32,
    parameter int unsigned MaxWait     = 4
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic                   IReq,
    input  logic [AddressSize-1:0] IAddress,
    output logic                   IReady,
    output logic                   IValid,
    output logic [WordSize-1:0]    IData,
    input  logic                   DReq,
    input  logic                   DWrite,
    input  logic                   DWriteL,
    input  logic                   DWriteR,
    input  logic [AddressSize-1:0] DAddress,
    input  logic [WordSize-1:0]    DWriteData,
    output logic                   DReady,
    output logic                   DValid,
    output logic [WordSize-1:0]    DData,
    output logic                   MemWriteEn,
    output logic                   MemWriteL,
    output logic                   MemWriteR,
    output logic                   MemReadEn,
    output logic [AddressSize-1:0] MemAddress,
    output logic [WordSize-1:0]    MemWriteData,
    input  logic [WordSize-1:0]    MemReadData
);

    state_t              state;
    logic [WaitBits-1:0] i_wait;
    logic [WaitBits-1:0] wait_next;
    logic                i_pri;
    logic                i_win;
    logic                d_win;
    owner_t              issue;

    // Grants are gated by reset so both readies read 0 while held in reset.
    assign i_pri = (state == ST_IPRI);
    assign d_win = nReset & DReq & ~(i_pri & IReq);
    assign i_win = nReset & IReq & ~d_win;

    assign IReady = i_win;
    assign DReady = d_win;

    assign wait_next = (IReq && !i_win) ? i_wait + WaitBits'(1) : '0;

    assign issue = (d_win && !DWrite) ? OWN_D :
                   (i_win            ? OWN_I : OWN_NONE);

    // Priority FSM: one cycle of instruction priority once the wait bound is hit.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= ST_DPRI;
            i_wait <= '0;
        end else begin
            i_wait <= wait_next;
            state  <= (wait_next == WaitBits'(MaxWait)) ? ST_IPRI : ST_DPRI;
        end
    end

    // One-cycle memory command; everything returns to 0 on a cycle without a transfer.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            MemWriteEn   <= 1'b0;
            MemWriteL    <= 1'b0;
            MemWriteR    <= 1'b0;
            MemReadEn    <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
        end else begin
            MemWriteEn   <= 1'b0;
            MemWriteL    <= 1'b0;
            MemWriteR    <= 1'b0;
            MemReadEn    <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            if (d_win) begin
                MemAddress <= DAddress;
                if (DWrite) begin
                    MemWriteEn   <= 1'b1;
                    MemWriteL    <= DWriteL;
                    MemWriteR    <= DWriteR & ~DWriteL;
                    MemWriteData <= DWriteData;
                end else begin
                    MemReadEn <= 1'b1;
                end
            end else if (i_win) begin
                MemAddress <= IAddress;
                MemReadEn  <= 1'b1;
            end
        end
    end

    mem_arb_return #(
        .WordSize (WordSize)
    ) u_return (
        .Clock         (Clock),
        .nReset        (nReset),
        .issue         (issue),
        .mem_read_data (MemReadData),
        .i_valid       (IValid),
        .i_data        (IData),
        .d_valid       (DValid),
        .d_data        (DData)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed little-endian memory model.
module tb_mem_arbiter;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        IReq;
    logic [15:0] IAddress;
    logic        IReady;
    logic        IValid;
    logic [31:0] IData;
    logic        DReq;
    logic        DWrite;
    logic        DWriteL;
    logic        DWriteR;
    logic [15:0] DAddress;
    logic [31:0] DWriteData;
    logic        DReady;
    logic        DValid;
    logic [31:0] DData;
    logic        MemWriteEn;
    logic        MemWriteL;
    logic        MemWriteR;
    logic        MemReadEn;
    logic [15:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData = 32'h0;

    int tests = 0;
    int fails = 0;
    logic mem_init = 1'b0;
    logic [7:0] mem [0:65535];

    always #5 Clock = ~Clock;

    mem_arbiter #(
        .AddressSize (16),
        .WordSize    (32),
        .MaxWait     (4)
    ) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .IReq         (IReq),
        .IAddress     (IAddress),
        .IReady       (IReady),
        .IValid       (IValid),
        .IData        (IData),
        .DReq         (DReq),
        .DWrite       (DWrite),
        .DWriteL      (DWriteL),
        .DWriteR      (DWriteR),
        .DAddress     (DAddress),
        .DWriteData   (DWriteData),
        .DReady       (DReady),
        .DValid       (DValid),
        .DData        (DData),
        .MemWriteEn   (MemWriteEn),
        .MemWriteL    (MemWriteL),
        .MemWriteR    (MemWriteR),
        .MemReadEn    (MemReadEn),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemReadData  (MemReadData)
    );

    function automatic logic [31:0] init_word(input int unsigned w);
        case (w)
            0:       return 32'h1111_0000;
            1:       return 32'h2222_0004;
            2:       return 32'h3333_0008;
            3:       return 32'h4444_000C;
            4:       return 32'hDEAD_BEEF;
            default: return 32'h0;
        endcase
    endfunction

    // Synchronous memory: L = upper halfword, R = lower halfword, neither = full word.
    always @(posedge Clock) begin
        if (mem_init) begin
            for (int k = 0; k < 256; k++)
                mem[16'(k)] <= 8'(init_word(k / 4) >> (8 * (k % 4)));
        end else begin
            if (MemWriteEn) begin
                if (MemWriteL || !MemWriteR) begin
                    mem[MemAddress + 16'd2] <= MemWriteData[23:16];
                    mem[MemAddress + 16'd3] <= MemWriteData[31:24];
                end
                if (!MemWriteL) begin
                    mem[MemAddress]         <= MemWriteData[7:0];
                    mem[MemAddress + 16'd1] <= MemWriteData[15:8];
                end
            end
            if (MemReadEn)
                MemReadData <= {mem[MemAddress + 16'd3], mem[MemAddress + 16'd2],
                                mem[MemAddress + 16'd1], mem[MemAddress]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        IReq = 1'b0; IAddress = 16'h0;
        DReq = 1'b0; DWrite = 1'b0; DWriteL = 1'b0; DWriteR = 1'b0;
        DAddress = 16'h0; DWriteData = 32'h0;
    endtask

    task automatic contend(input logic [15:0] ia, input logic [15:0] da);
        IReq = 1'b1; IAddress = ia;
        DReq = 1'b1; DWrite = 1'b0; DWriteL = 1'b0; DWriteR = 1'b0; DAddress = da;
    endtask

    typedef struct {
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwrite;
        logic        wl;
        logic        wr;
        logic [15:0] daddr;
        logic [31:0] wdata;
        logic        e_irdy;
        logic        e_drdy;
        logic        e_rd;
        logic        e_we;
        logic        e_wl;
        logic        e_wr;
        logic [15:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_iv;
        logic [31:0] e_idata;
        logic        e_dv;
        logic [31:0] e_ddata;
    } vec_t;

    localparam int NV = 20;
    vec_t v [NV];

    initial begin
        // ireq iaddr dreq dwr wl wr daddr wdata | irdy drdy rd we wl wr maddr mwdata iv idata dv ddata
        v[0]  = '{1, 16'h10, 0, 0, 0, 0, 16'h0,  32'h0,        1, 0, 0, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        0, 32'h0};
        v[1]  = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 1, 0, 0, 0, 16'h10, 32'h0,        0, 32'h0,        0, 32'h0};
        v[2]  = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 0, 0, 0, 0, 16'h0,  32'h0,        1, 32'hDEADBEEF, 0, 32'h0};
        v[3]  = '{0, 16'h0,  1, 1, 0, 0, 16'h20, 32'h12345678, 0, 1, 0, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        0, 32'h0};
        v[4]  = '{0, 16'h0,  1, 0, 0, 0, 16'h20, 32'h0,        0, 1, 0, 1, 0, 0, 16'h20, 32'h12345678, 0, 32'h0,        0, 32'h0};
        v[5]  = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 1, 0, 0, 0, 16'h20, 32'h0,        0, 32'h0,        0, 32'h0};
        v[6]  = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 0, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        1, 32'h12345678};
        v[7]  = '{0, 16'h0,  1, 1, 1, 0, 16'h40, 32'hAABBCCDD, 0, 1, 0, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        0, 32'h0};
        v[8]  = '{0, 16'h0,  1, 1, 0, 1, 16'h40, 32'h11223344, 0, 1, 0, 1, 1, 0, 16'h40, 32'hAABBCCDD, 0, 32'h0,        0, 32'h0};
        v[9]  = '{0, 16'h0,  1, 1, 1, 1, 16'h44, 32'hFFFFFFFF, 0, 1, 0, 1, 0, 1, 16'h40, 32'h11223344, 0, 32'h0,        0, 32'h0};
        v[10] = '{0, 16'h0,  1, 0, 0, 0, 16'h40, 32'h0,        0, 1, 0, 1, 1, 0, 16'h44, 32'hFFFFFFFF, 0, 32'h0,        0, 32'h0};
        v[11] = '{0, 16'h0,  1, 0, 0, 0, 16'h44, 32'h0,        0, 1, 1, 0, 0, 0, 16'h40, 32'h0,        0, 32'h0,        0, 32'h0};
        v[12] = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 1, 0, 0, 0, 16'h44, 32'h0,        0, 32'h0,        1, 32'hAABB3344};
        v[13] = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 0, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        1, 32'hFFFF0000};
        v[14] = '{1, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        1, 0, 0, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        0, 32'h0};
        v[15] = '{0, 16'h0,  1, 0, 0, 0, 16'h4,  32'h0,        0, 1, 1, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        0, 32'h0};
        v[16] = '{1, 16'h8,  0, 0, 0, 0, 16'h0,  32'h0,        1, 0, 1, 0, 0, 0, 16'h4,  32'h0,        1, 32'h11110000, 0, 32'h0};
        v[17] = '{0, 16'h0,  1, 0, 0, 0, 16'hC,  32'h0,        0, 1, 1, 0, 0, 0, 16'h8,  32'h0,        0, 32'h0,        1, 32'h22220004};
        v[18] = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 1, 0, 0, 0, 16'hC,  32'h0,        1, 32'h33330008, 0, 32'h0};
        v[19] = '{0, 16'h0,  0, 0, 0, 0, 16'h0,  32'h0,        0, 0, 0, 0, 0, 0, 16'h0,  32'h0,        0, 32'h0,        1, 32'h4444000C};

        // Reset state, with requests asserted to show the readies are gated.
        nReset = 1'b0;
        idle_inputs();
        contend(16'h10, 16'h20);
        DWrite = 1'b1; DWriteL = 1'b1;
        mem_init = 1'b1;
        @(posedge Clock); #1;
        mem_init = 1'b0;
        @(negedge Clock);
        chk("rst iready", 32'(IReady), 32'h0);
        chk("rst dready", 32'(DReady), 32'h0);
        chk("rst mem strobes", {28'h0, MemWriteEn, MemWriteL, MemWriteR, MemReadEn}, 32'h0);
        chk("rst mem addr", 32'(MemAddress), 32'h0);
        chk("rst valids", {30'h0, IValid, DValid}, 32'h0);
        @(posedge Clock); #1;
        idle_inputs();
        nReset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge Clock); #1;
            IReq = v[i].ireq; IAddress = v[i].iaddr;
            DReq = v[i].dreq; DWrite = v[i].dwrite; DWriteL = v[i].wl; DWriteR = v[i].wr;
            DAddress = v[i].daddr; DWriteData = v[i].wdata;
            @(negedge Clock);
            chk($sformatf("v%0d iready", i), 32'(IReady), 32'(v[i].e_irdy));
            chk($sformatf("v%0d dready", i), 32'(DReady), 32'(v[i].e_drdy));
            chk($sformatf("v%0d mem_read_en", i), 32'(MemReadEn), 32'(v[i].e_rd));
            chk($sformatf("v%0d mem_write_en", i), 32'(MemWriteEn), 32'(v[i].e_we));
            chk($sformatf("v%0d mem_write_l", i), 32'(MemWriteL), 32'(v[i].e_wl));
            chk($sformatf("v%0d mem_write_r", i), 32'(MemWriteR), 32'(v[i].e_wr));
            chk($sformatf("v%0d mem_addr", i), 32'(MemAddress), 32'(v[i].e_maddr));
            chk($sformatf("v%0d mem_wdata", i), MemWriteData, v[i].e_mwdata);
            chk($sformatf("v%0d ivalid", i), 32'(IValid), 32'(v[i].e_iv));
            chk($sformatf("v%0d idata", i), IData, v[i].e_idata);
            chk($sformatf("v%0d dvalid", i), 32'(DValid), 32'(v[i].e_dv));
            chk($sformatf("v%0d ddata", i), DData, v[i].e_ddata);
        end

        // Starvation bound: continuous contention gives I every fifth cycle.
        for (int c = 0; c < 10; c++) begin
            @(posedge Clock); #1;
            contend(16'h8, 16'h4);
            @(negedge Clock);
            chk($sformatf("starve c%0d iready", c), 32'(IReady), (c == 4 || c == 9) ? 32'h1 : 32'h0);
            chk($sformatf("starve c%0d dready", c), 32'(DReady), (c == 4 || c == 9) ? 32'h0 : 32'h1);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #1;
            idle_inputs();
        end

        // Reset clears a partly accumulated wait count.
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #1;
            contend(16'h8, 16'h4);
        end
        @(posedge Clock); #1;
        nReset = 1'b0;
        @(posedge Clock); #1;
        nReset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            chk($sformatf("wait rst c%0d iready", c), 32'(IReady), (c == 4) ? 32'h1 : 32'h0);
            @(posedge Clock); #1;
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) @(posedge Clock);
        #1;

        // Reset while an instruction read is in flight.
        IReq = 1'b1; IAddress = 16'h10;
        @(negedge Clock);
        chk("midrst c0 iready", 32'(IReady), 32'h1);
        @(posedge Clock); #1;
        nReset = 1'b0;
        contend(16'h10, 16'h4);
        @(negedge Clock);
        chk("midrst c1 readies", {30'h0, IReady, DReady}, 32'h0);
        chk("midrst c1 mem strobes", {28'h0, MemWriteEn, MemWriteL, MemWriteR, MemReadEn}, 32'h0);
        chk("midrst c1 mem addr", 32'(MemAddress), 32'h0);
        chk("midrst c1 valids", {30'h0, IValid, DValid}, 32'h0);
        @(posedge Clock); #1;
        nReset = 1'b1;
        @(negedge Clock);
        chk("midrst c2 ivalid", 32'(IValid), 32'h0);
        chk("midrst c2 dready", 32'(DReady), 32'h1);
        chk("midrst c2 iready", 32'(IReady), 32'h0);
        @(posedge Clock); #1;
        idle_inputs();
        @(negedge Clock);
        chk("midrst c3 ivalid", 32'(IValid), 32'h0);
        chk("midrst c3 mem_read_en", 32'(MemReadEn), 32'h1);
        @(negedge Clock);
        chk("midrst c4 dvalid", 32'(DValid), 32'h1);
        chk("midrst c4 ddata", DData, 32'h22220004);
        chk("midrst c4 ivalid", 32'(IValid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
